alu_operand_loader: RTL

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

---
 rtl/alu_operand_loader.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_operand_loader.sv
// alu_operand_loader
//
// Builds one ALU operation (operand A, operand B, opcode) from six operand
// switches and four opcode switches. Each value is captured by pressing the
// load button. A clear button returns to an empty entry at any point.
//
// Configuration macro: LOADER_DEBOUNCE_EN
//   defined   - each synchronized button level must hold for DEBOUNCE_CYCLES
//               consecutive cycles before it is accepted
//   undefined - the accepted level is the synchronized level, and
//               DEBOUNCE_CYCLES has no effect
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sw         operand switches (raw)
//   op_sw      opcode switches (raw)
//   btn_load   load push-button (raw, asynchronous, active-high)
//   btn_clear  clear push-button (raw, asynchronous, active-high)
//   a, b       registered operands for the ALU
//   op_code    registered opcode for the ALU
//   valid      a/b/op_code together form a complete, legal operation
//   stage      current entry state (S_A/S_B/S_OP/S_RDY), drives status LEDs
//   op_err     one-cycle pulse when an opcode above 4'b1011 is rejected
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sw,
  input  logic [3:0] op_sw,
  input  logic       btn_load,
  input  logic       btn_clear,
  output logic [5:0] a,
  output logic [5:0] b,
  output logic [3:0] op_code,
  output logic       valid,
  output logic [1:0] stage,
  output logic       op_err
);

  localparam int         NUM_BTN   = 2;
  localparam int         BTN_LOAD  = 0;
  localparam int         BTN_CLEAR = 1;
  localparam logic [3:0] OP_MAX    = 4'b1011;

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RDY = 2'b11
  } state_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [1:0]         fill_reg;

  assign btn_raw = {btn_clear, btn_load};

  // Shifts in ones after reset. Once fill_reg[1] is set, the synchronizers
  // hold real button samples instead of their reset zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_reg <= '0;
    end else begin
      fill_reg <= {fill_reg[0], 1'b1};
    end
  end

  generate
    if (DEBOUNCE_CYCLES < 1) begin : g_param_check
      $error("DEBOUNCE_CYCLES must be at least 1");
    end

    genvar gi;
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic sync1_reg;
      logic sync2_reg;
      logic level_prev_reg;
      logic armed_reg;

`ifdef LOADER_DEBOUNCE_EN
      localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_reg;
      logic             accepted_reg;

      // The level is accepted on the DEBOUNCE_CYCLES-th consecutive cycle
      // of disagreement. Any cycle of agreement restarts the count.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg      <= '0;
          accepted_reg <= 1'b0;
        end else if (sync2_reg == accepted_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          accepted_reg <= sync2_reg;
          cnt_reg      <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign level[gi] = accepted_reg;
`else
      assign level[gi] = sync2_reg;
`endif

      // A button is armed only after it has been seen released following
      // reset. This stops a button held through reset from producing a press.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg      <= 1'b0;
          sync2_reg      <= 1'b0;
          level_prev_reg <= 1'b0;
          armed_reg      <= 1'b0;
        end else begin
          sync1_reg      <= btn_raw[gi];
          sync2_reg      <= sync1_reg;
          level_prev_reg <= level[gi];
          if (fill_reg[1] && !sync2_reg) begin
            armed_reg <= 1'b1;
          end
        end
      end

      assign press[gi] = level[gi] & ~level_prev_reg & armed_reg;
    end
  endgenerate

  // Entry FSM together with its operand and opcode registers.
  state_t     state_reg, state_next;
  logic [5:0] a_reg, a_next;
  logic [5:0] b_reg, b_next;
  logic [3:0] op_reg, op_next;
  logic       valid_reg, valid_next;
  logic       op_err_reg, op_err_next;
  logic       load_ev;
  logic       clear_ev;

  assign load_ev  = press[BTN_LOAD];
  assign clear_ev = press[BTN_CLEAR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_A;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      valid_reg  <= 1'b0;
      op_err_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      valid_reg  <= valid_next;
      op_err_reg <= op_err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    valid_next  = valid_reg;
    op_err_next = 1'b0;
    // A clear always wins. A load in the same cycle is dropped.
    if (clear_ev) begin
      state_next = S_A;
      a_next     = '0;
      b_next     = '0;
      op_next    = '0;
      valid_next = 1'b0;
    end else if (load_ev) begin
      unique case (state_reg)
        S_A: begin
          a_next     = sw;
          state_next = S_B;
        end
        S_B: begin
          b_next     = sw;
          state_next = S_OP;
        end
        S_OP: begin
          if (op_sw <= OP_MAX) begin
            op_next    = op_sw;
            valid_next = 1'b1;
            state_next = S_RDY;
          end else begin
            op_err_next = 1'b1;
          end
        end
        S_RDY: begin
          // A load here starts a new entry, with A already captured.
          a_next     = sw;
          valid_next = 1'b0;
          state_next = S_B;
        end
        default: state_next = S_A;
      endcase
    end
  end

  assign a       = a_reg;
  assign b       = b_reg;
  assign op_code = op_reg;
  assign valid   = valid_reg;
  assign stage   = state_reg;
  assign op_err  = op_err_reg;

endmodule
